// File: rtl/rx_fifo_admit_ctrl.sv
// rx_fifo_admit_ctrl: frame admission in front of a flagless RX FIFO.
// Tracks occupancy, drops frames that cannot fit, truncates oversize ones.
module rx_fifo_admit_ctrl #(
  parameter int DEPTH     = 2048,
  parameter int MAX_FRAME = 1518,
  parameter int CNT_W     = 16,
  localparam int OW       = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_error,
  output logic [7:0]       fifo_data,
  output logic             fifo_valid,
  output logic             fifo_last,
  output logic             fifo_error,
  input  logic             rd_pop,
  output logic [OW-1:0]    occupancy,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_err,
  output logic [CNT_W-1:0] frames_drop,
  output logic             drop_pulse
);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_e;

  localparam logic [OW:0]      DEPTH_V = (OW+1)'(DEPTH);
  localparam logic [OW:0]      MAX_V   = (OW+1)'(MAX_FRAME);
  localparam logic [OW-1:0]    MAX_C   = OW'(MAX_FRAME);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [7:0]       fifo_data_q, fifo_data_d;
  logic             fifo_valid_q, fifo_valid_d;
  logic             fifo_last_q, fifo_last_d;
  logic             fifo_error_q, fifo_error_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [OW-1:0]    byte_cnt_q, byte_cnt_d;
  logic             err_seen_q, err_seen_d;
  logic [CNT_W-1:0] ok_q, ok_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             drop_pulse_q, drop_pulse_d;

  logic [OW:0]      free;
  logic             admit;
  logic [OW-1:0]    cnt_inc;
  logic             trunc;
  logic             pop_ok;
  logic             inc_ok, inc_err, inc_drop;

  // The byte still in the output register is already committed space.
  assign free    = DEPTH_V - {1'b0, occ_q}
                 - {{OW{1'b0}}, fifo_valid_q};
  assign admit   = free >= MAX_V;
  assign cnt_inc = byte_cnt_q + OW'(1);
  assign trunc   = cnt_inc == MAX_C;
  assign pop_ok  = rd_pop && (occ_q != '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: frame boundaries and admission/truncation decisions
  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      unique case (state_q)
        IDLE: if (!in_last) state_d = admit ? PASS : DROP;
        PASS: begin
          if (in_last)    state_d = IDLE;
          else if (trunc) state_d = DROP;
        end
        DROP: if (in_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: forwarded byte, per-frame tracking and counter strobes
  always_comb begin
    fifo_data_d  = fifo_data_q;
    fifo_valid_d = 1'b0;
    fifo_last_d  = 1'b0;
    fifo_error_d = 1'b0;
    byte_cnt_d   = byte_cnt_q;
    err_seen_d   = err_seen_q;
    drop_pulse_d = 1'b0;
    inc_ok       = 1'b0;
    inc_err      = 1'b0;
    inc_drop     = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          if (admit) begin
            fifo_data_d  = in_data;
            fifo_valid_d = 1'b1;
            byte_cnt_d   = OW'(1);
            err_seen_d   = in_error;
            if (in_last) begin
              fifo_last_d  = 1'b1;
              fifo_error_d = in_error;
              inc_err      = in_error;
              inc_ok       = !in_error;
            end
          end else begin
            drop_pulse_d = 1'b1;
            inc_drop     = 1'b1;
          end
        end
        PASS: begin
          fifo_data_d  = in_data;
          fifo_valid_d = 1'b1;
          byte_cnt_d   = cnt_inc;
          err_seen_d   = err_seen_q | in_error;
          if (in_last) begin
            fifo_last_d  = 1'b1;
            fifo_error_d = err_seen_q | in_error;
            inc_err      = fifo_error_d;
            inc_ok       = !fifo_error_d;
          end else if (trunc) begin
            fifo_last_d  = 1'b1;
            fifo_error_d = 1'b1;
            inc_err      = 1'b1;
          end
        end
        default: ;
      endcase
    end
    ok_d   = (inc_ok && ok_q != CNT_MAX)
           ? ok_q + CNT_W'(1) : ok_q;
    err_d  = (inc_err && err_q != CNT_MAX)
           ? err_q + CNT_W'(1) : err_q;
    drop_d = (inc_drop && drop_q != CNT_MAX)
           ? drop_q + CNT_W'(1) : drop_q;
    occ_d  = occ_q + OW'(fifo_valid_q) - OW'(pop_ok);
  end

  // Datapath, occupancy and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data_q  <= '0;
      fifo_valid_q <= 1'b0;
      fifo_last_q  <= 1'b0;
      fifo_error_q <= 1'b0;
      occ_q        <= '0;
      byte_cnt_q   <= '0;
      err_seen_q   <= 1'b0;
      ok_q         <= '0;
      err_q        <= '0;
      drop_q       <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      fifo_data_q  <= fifo_data_d;
      fifo_valid_q <= fifo_valid_d;
      fifo_last_q  <= fifo_last_d;
      fifo_error_q <= fifo_error_d;
      occ_q        <= occ_d;
      byte_cnt_q   <= byte_cnt_d;
      err_seen_q   <= err_seen_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
      drop_q       <= drop_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  assign fifo_data   = fifo_data_q;
  assign fifo_valid  = fifo_valid_q;
  assign fifo_last   = fifo_last_q;
  assign fifo_error  = fifo_error_q;
  assign occupancy   = occ_q;
  assign frames_ok   = ok_q;
  assign frames_err  = err_q;
  assign frames_drop = drop_q;
  assign drop_pulse  = drop_pulse_q;

endmodule
